// File: rtl/spn_sbox_pkg.sv
// Shared S-box tables, nibble-parallel substitution helpers and the core FSM state type.
// Helpers work on SPN_MAX_DW-bit vectors; callers zero-extend their block and truncate the result.
package spn_sbox_pkg;

    localparam int SPN_MAX_DW = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } spn_state_t;

    // Entry n of each table sits at bits [n*4 +: 4].
    localparam logic [63:0] SBOX_TABLE     = 64'h2174_8FE3_DA09_B65C;
    localparam logic [63:0] SBOX_INV_TABLE = 64'hA970_364B_D21C_8FE5;

    function automatic logic [SPN_MAX_DW-1:0] sbox_substitute(input logic [SPN_MAX_DW-1:0] x);
        logic [SPN_MAX_DW-1:0] y;
        y = '0;
        for (int unsigned i = 0; i < SPN_MAX_DW / 4; i++) begin
            y[i*4 +: 4] = SBOX_TABLE[int'(x[i*4 +: 4])*4 +: 4];
        end
        return y;
    endfunction

    function automatic logic [SPN_MAX_DW-1:0] sbox_inv_substitute(input logic [SPN_MAX_DW-1:0] x);
        logic [SPN_MAX_DW-1:0] y;
        y = '0;
        for (int unsigned i = 0; i < SPN_MAX_DW / 4; i++) begin
            y[i*4 +: 4] = SBOX_INV_TABLE[int'(x[i*4 +: 4])*4 +: 4];
        end
        return y;
    endfunction

endpackage

// File: rtl/spn_round_bidir.sv
// One combinational SPN round, encrypt or decrypt, selected by mode.
// Decrypt round rc undoes encrypt round NR-1-rc, so NR decrypt rounds invert NR encrypt rounds.
module spn_round_bidir
    import spn_sbox_pkg::*;
#(
    parameter int DW  = 16,
    parameter int NR  = 4,
    parameter int ROT = DW / 2,
    parameter int RCW = $clog2(NR + 1)
) (
    input  logic [DW-1:0]          state_in,
    input  logic                   mode,
    input  logic [RCW-1:0]         rc,
    input  logic [(NR+1)*DW-1:0]   keys,
    output logic [DW-1:0]          state_out
);

    localparam int unsigned R = ROT % DW;

    function automatic logic [DW-1:0] rotl(input logic [DW-1:0] x);
        return (x << R) | (x >> (DW - R));
    endfunction

    function automatic logic [DW-1:0] rotr(input logic [DW-1:0] x);
        return (x >> R) | (x << (DW - R));
    endfunction

    logic [DW-1:0] k_fwd, k_inv, k_last;
    logic [DW-1:0] enc_x, enc_y, dec_x, dec_y;
    logic          is_first, is_last;

    always_comb begin
        k_fwd    = keys[int'(rc)*DW +: DW];
        k_inv    = keys[(NR - 1 - int'(rc))*DW +: DW];
        k_last   = keys[NR*DW +: DW];
        is_first = (rc == '0);
        is_last  = (rc == RCW'(NR - 1));

        enc_x = state_in ^ k_fwd;
        enc_y = rotl(DW'(sbox_substitute(SPN_MAX_DW'(enc_x)))) ^ (is_last ? k_last : '0);

        // The final whitening key is stripped before the first inverse round.
        dec_x = state_in ^ (is_first ? k_last : '0);
        dec_y = DW'(sbox_inv_substitute(SPN_MAX_DW'(rotr(dec_x)))) ^ k_inv;

        state_out = mode ? dec_y : enc_y;
    end

endmodule

// File: rtl/spn_iter_core.sv
// Iterative SPN cipher core: one round per clock, NR-cycle latency, valid/ready on both sides.
// Request operands are latched at accept so the in-flight result ignores later input changes.
module spn_iter_core
    import spn_sbox_pkg::*;
#(
    parameter int DW  = 16,
    parameter int NR  = 4,
    parameter int ROT = DW / 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   mode,
    input  logic [DW-1:0]          data_in,
    input  logic [(NR+1)*DW-1:0]   round_keys,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          data_out,
    output logic                   busy
);

    localparam int RCW = $clog2(NR + 1);

    spn_state_t               fsm_q, fsm_d;
    logic [DW-1:0]            blk_q, blk_d;
    logic [DW-1:0]            dout_q, dout_d;
    logic [RCW-1:0]           rc_q, rc_d;
    logic [(NR+1)*DW-1:0]     keys_q, keys_d;
    logic                     mode_q, mode_d;
    logic                     ovalid_q, ovalid_d;
    logic [DW-1:0]            round_out;

    spn_round_bidir #(
        .DW  (DW),
        .NR  (NR),
        .ROT (ROT),
        .RCW (RCW)
    ) u_round (
        .state_in  (blk_q),
        .mode      (mode_q),
        .rc        (rc_q),
        .keys      (keys_q),
        .state_out (round_out)
    );

    always_comb begin
        fsm_d    = fsm_q;
        blk_d    = blk_q;
        dout_d   = dout_q;
        rc_d     = rc_q;
        keys_d   = keys_q;
        mode_d   = mode_q;
        ovalid_d = ovalid_q;
        unique case (fsm_q)
            ST_IDLE: begin
                if (in_valid) begin
                    blk_d  = data_in;
                    mode_d = mode;
                    keys_d = round_keys;
                    rc_d   = '0;
                    fsm_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                blk_d = round_out;
                rc_d  = rc_q + RCW'(1);
                if (rc_q == RCW'(NR - 1)) begin
                    rc_d     = '0;
                    dout_d   = round_out;
                    ovalid_d = 1'b1;
                    fsm_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    dout_d   = '0;
                    ovalid_d = 1'b0;
                    fsm_d    = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q    <= ST_IDLE;
            blk_q    <= '0;
            dout_q   <= '0;
            rc_q     <= '0;
            keys_q   <= '0;
            mode_q   <= 1'b0;
            ovalid_q <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            blk_q    <= blk_d;
            dout_q   <= dout_d;
            rc_q     <= rc_d;
            keys_q   <= keys_d;
            mode_q   <= mode_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign in_ready  = (fsm_q == ST_IDLE);
    assign busy      = (fsm_q != ST_IDLE);
    assign out_valid = ovalid_q;
    assign data_out  = dout_q;

endmodule

// File: tb/tb_spn_iter_core.sv
// Self-checking bench for spn_iter_core: cipher model plus protocol model, compared every cycle,
// directed vectors with hand-computed values, and random round trips for NR = 1, 4 and 15.
module tb_spn_iter_core;

    localparam int DW = 16;
    localparam int NR = 4;
    localparam int KW = 16 * DW;

    localparam logic [3:0] TB_S [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                         4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic                  in_valid, in_ready, mode, out_valid, out_ready, busy;
    logic [DW-1:0]         data_in, data_out;
    logic [(NR+1)*DW-1:0]  round_keys;

    int n_total = 0;
    int n_bad   = 0;

    spn_iter_core #(.DW(DW), .NR(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode       (mode),
        .data_in    (data_in),
        .round_keys (round_keys),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] subst(input logic [15:0] x, input bit inv);
        logic [15:0] y;
        y = '0;
        for (int n = 0; n < 4; n++) begin
            if (!inv) begin
                y[n*4 +: 4] = TB_S[x[n*4 +: 4]];
            end else begin
                for (int j = 0; j < 16; j++)
                    if (TB_S[j] == x[n*4 +: 4]) y[n*4 +: 4] = 4'(j);
            end
        end
        return y;
    endfunction

    function automatic logic [15:0] model_enc(input logic [15:0] p, input logic [KW-1:0] k, input int nr);
        logic [15:0] x;
        x = p;
        for (int r = 0; r < nr; r++) begin
            x = subst(x ^ k[r*16 +: 16], 1'b0);
            x = {x[7:0], x[15:8]};
        end
        return x ^ k[nr*16 +: 16];
    endfunction

    function automatic logic [15:0] model_dec(input logic [15:0] c, input logic [KW-1:0] k, input int nr);
        logic [15:0] x;
        x = c ^ k[nr*16 +: 16];
        for (int r = nr - 1; r >= 0; r--) begin
            x = {x[7:0], x[15:8]};
            x = subst(x, 1'b1) ^ k[r*16 +: 16];
        end
        return x;
    endfunction

    // Protocol model: an accepted request becomes visible NR edges later and stays until taken.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_age  = 0;
    logic [15:0] m_exp  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_age  = 0;
            m_exp  = '0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1'b1;
                m_age  = 0;
                m_exp  = mode ? model_dec(data_in, KW'(round_keys), NR)
                              : model_enc(data_in, KW'(round_keys), NR);
            end
        end else if (!m_done) begin
            m_age++;
            if (m_age == NR) m_done = 1'b1;
        end else if (out_ready) begin
            m_busy = 1'b0;
            m_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("cmp_in_ready", 32'(in_ready), 32'(!m_busy));
        chk("cmp_busy", 32'(busy), 32'(m_busy));
        chk("cmp_out_valid", 32'(out_valid), 32'(m_done));
        chk("cmp_data_out", 32'(data_out), 32'(m_done ? m_exp : 16'h0));
    end

    // Inputs change at posedge+2; returns at accept edge +2 with in_valid dropped.
    task automatic start_op(input logic m, input logic [15:0] d, input logic [(NR+1)*DW-1:0] k);
        bit acc;
        acc = 1'b0;
        mode = m; data_in = d; round_keys = k; in_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = in_ready;
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        chk("accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_result(output logic [15:0] r, output int lat);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); lat++; #2;
            if (out_valid) break;
        end
        r = data_out;
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
    endtask

    // Round-trip instances for the boundary round counts.
    for (genvar g = 0; g < 2; g++) begin : g_rt
        localparam int N = (g == 0) ? 1 : 15;
        logic                 g_rst, iv, ir, md, ov, orr, bz;
        logic [15:0]          di, dq;
        logic [(N+1)*16-1:0]  rk;
        bit                   done_g = 1'b0;

        spn_iter_core #(.DW(16), .NR(N)) u_dut (
            .clk        (clk),
            .rst        (g_rst),
            .in_valid   (iv),
            .in_ready   (ir),
            .mode       (md),
            .data_in    (di),
            .round_keys (rk),
            .out_valid  (ov),
            .out_ready  (orr),
            .data_out   (dq),
            .busy       (bz)
        );

        task automatic g_op(input logic m, input logic [15:0] d, output logic [15:0] r, output int lat);
            bit acc;
            acc = 1'b0;
            md = m; di = d; iv = 1'b1;
            for (int i = 0; i < 50 && !acc; i++) begin
                acc = ir;
                @(posedge clk); #2;
            end
            iv = 1'b0;
            chk("g_accept", 32'(acc), 32'd1);
            lat = 0;
            for (int i = 0; i < 100; i++) begin
                @(posedge clk); lat++; #2;
                if (ov) break;
            end
            r = dq;
            orr = 1'b1;
            @(posedge clk); #2;
            orr = 1'b0;
        endtask

        initial begin
            logic [15:0] p, c, q;
            int          lat;
            g_rst = 1'b1; iv = 1'b0; md = 1'b0; orr = 1'b0; di = '0; rk = '0;
            @(posedge clk); @(posedge clk); #2;
            g_rst = 1'b0;
            for (int t = 0; t < 1000; t++) begin
                for (int i = 0; i < N + 1; i++) rk[i*16 +: 16] = 16'($urandom());
                p = 16'($urandom());
                g_op(1'b0, p, c, lat);
                chk("g_enc_latency", 32'(lat), 32'(N));
                chk("g_enc_model", 32'(c), 32'(model_enc(p, KW'(rk), N)));
                g_op(1'b1, c, q, lat);
                chk("g_roundtrip", 32'(q), 32'(p));
            end
            done_g = 1'b1;
        end
    end

    initial begin
        logic [(NR+1)*DW-1:0] kref, kr;
        logic [15:0]          r, p, c;
        int                   lat, prev, nacc;

        kref = {16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
        rst = 1'b1; in_valid = 1'b0; mode = 1'b0; out_ready = 1'b0; data_in = '0; round_keys = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        #1 rst = 1'b0;

        chk("model_pin_enc", 32'(model_enc(16'h1234, KW'(kref), NR)), 32'h3EDC);

        // Known-answer encrypt, then hold the result in DONE for six cycles.
        start_op(1'b0, 16'h1234, kref);
        wait_result(r, lat);
        chk("enc_latency", 32'(lat), 32'(NR));
        chk("enc_known", 32'(r), 32'h3EDC);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_data_out", 32'(data_out), 32'h3EDC);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        #1 ack();
        chk("after_ack_in_ready", 32'(in_ready), 32'd1);
        chk("after_ack_out_valid", 32'(out_valid), 32'd0);

        start_op(1'b1, 16'h3EDC, kref);
        wait_result(r, lat);
        chk("dec_latency", 32'(lat), 32'(NR));
        chk("dec_known", 32'(r), 32'h1234);
        ack();

        // Operands scrambled right after accept must not leak into the result.
        start_op(1'b0, 16'h1234, kref);
        round_keys = '1; mode = 1'b1; data_in = 16'hA5A5;
        wait_result(r, lat);
        chk("late_change", 32'(r), 32'h3EDC);
        ack();

        // Asynchronous reset at rc=2.
        start_op(1'b0, 16'h1234, kref);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1; #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_data_out", 32'(data_out), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #2 rst = 1'b0;
        for (int i = 0; i < NR + 3; i++) begin
            @(posedge clk); #1;
            chk("no_pulse_after_rst", 32'(out_valid), 32'd0);
        end
        #1;

        // Asynchronous reset while holding a result.
        start_op(1'b0, 16'h1234, kref);
        wait_result(r, lat);
        #1 rst = 1'b1; #1;
        chk("arst_done_out_valid", 32'(out_valid), 32'd0);
        chk("arst_done_data_out", 32'(data_out), 32'd0);
        @(posedge clk); #2 rst = 1'b0;

        start_op(1'b1, 16'h3EDC, kref);
        wait_result(r, lat);
        chk("post_rst_latency", 32'(lat), 32'(NR));
        chk("post_rst_dec", 32'(r), 32'h1234);
        ack();

        // Back-to-back requests with in_valid and out_ready held high.
        mode = 1'b0; data_in = 16'hBEEF; round_keys = kref;
        in_valid = 1'b1; out_ready = 1'b1;
        prev = -1; nacc = 0;
        for (int cyc = 0; cyc < 80 && nacc < 4; cyc++) begin
            @(negedge clk);
            if (in_ready && in_valid) begin
                if (prev >= 0) chk("b2b_spacing", 32'(cyc - prev), 32'(NR + 2));
                prev = cyc;
                nacc++;
                data_in = data_in + 16'h1111;
            end
        end
        in_valid = 1'b0;
        chk("b2b_accepts", 32'(nacc), 32'd4);
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk); #2;

        // Random round trips at the default round count.
        for (int t = 0; t < 1000; t++) begin
            for (int i = 0; i < NR + 1; i++) kr[i*16 +: 16] = 16'($urandom());
            p = 16'($urandom());
            start_op(1'b0, p, kr);
            wait_result(c, lat);
            chk("rt4_latency", 32'(lat), 32'(NR));
            ack();
            start_op(1'b1, c, kr);
            wait_result(r, lat);
            chk("rt4_roundtrip", 32'(r), 32'(p));
            ack();
        end

        for (int i = 0; i < 60000 && !(g_rt[0].done_g && g_rt[1].done_g); i++) @(posedge clk);
        chk("gen_finished", 32'(g_rt[0].done_g && g_rt[1].done_g), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
